// File: rtl/regfile_sequencer_if.sv
// Instruction handshake and register-file port bundle for regfile_sequencer.
// The environment (master) issues instructions and owns the register file; the sequencer is the slave.
interface regfile_sequencer_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          inst_valid;
  logic          inst_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] imm;
  logic          WEN;
  logic [AW-1:0] RW;
  logic [DW-1:0] busW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic [DW-1:0] busX;
  logic [DW-1:0] busY;
  logic          done;
  logic [DW-1:0] result;

  modport master (
    output inst_valid, op, rd, rs, rt, imm, busX, busY,
    input  inst_ready, WEN, RW, busW, RX, RY, done, result
  );

  modport slave (
    input  inst_valid, op, rd, rs, rt, imm, busX, busY,
    output inst_ready, WEN, RW, busW, RX, RY, done, result
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Four-phase instruction sequencer: accept, read operands, execute, write back.
// One instruction in flight; the write-back lands before the next read, so no forwarding is needed.
module regfile_sequencer (
  input logic          Clk,
  input logic          Reset,
  regfile_sequencer_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_LI   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          hs_c;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [AW-1:0] rx_q;
  logic [AW-1:0] ry_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] alu_c;
  logic          ready_q;
  logic          wen_q;
  logic          done_q;

  assign hs_c = bus.inst_valid & (state == IDLE);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: every phase lasts one cycle, IDLE waits for a handshake
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (hs_c) next_state = READ;
      READ: next_state = EXEC;
      EXEC: next_state = WB;
      WB:   next_state = IDLE;
    endcase
  end

  // Result of the captured instruction on the latched operands
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_ADD:  alu_c = a_q + b_q;
      OP_SUB:  alu_c = a_q - b_q;
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_XOR:  alu_c = a_q ^ b_q;
      OP_SLT:  alu_c = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_ADDI: alu_c = a_q + imm_q;
      OP_LI:   alu_c = imm_q;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rw_q     <= '0;
      busw_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ready_q <= (next_state == IDLE);
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      if (hs_c) begin
        op_q  <= bus.op;
        rd_q  <= bus.rd;
        imm_q <= bus.imm;
        rx_q  <= bus.rs;
        ry_q  <= bus.rt;
      end
      if (state == READ) begin
        a_q <= bus.busX;
        b_q <= bus.busY;
      end
      // r0 is hardwired, so a write to it is suppressed but the instruction still retires
      if (state == EXEC) begin
        result_q <= alu_c;
        busw_q   <= alu_c;
        rw_q     <= rd_q;
        wen_q    <= (rd_q != AW'(0));
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.inst_ready = ready_q;
  assign bus.WEN        = wen_q;
  assign bus.RW         = rw_q;
  assign bus.busW       = busw_q;
  assign bus.RX         = rx_q;
  assign bus.RY         = ry_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register file, per-cycle reference model, directed and random stimulus.
module tb_regfile_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  regfile_sequencer_if bus();
  regfile_sequencer dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
  endtask

  // Attached register file: combinational reads, r0 reads zero, write on posedge when WEN
  logic [7:0] rf [8];
  bit rf_clr = 1'b1;
  assign bus.busX = (bus.RX == 3'd0) ? 8'h00 : rf[bus.RX];
  assign bus.busY = (bus.RY == 3'd0) ? 8'h00 : rf[bus.RY];
  always @(posedge Clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      rf_clr <= 1'b0;
    end else if (bus.WEN) begin
      rf[bus.RW] <= bus.busW;
    end
  end

  // Reference model: instruction semantics on an architectural register array
  function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] imm);
    int sa, sb;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    case (op)
      3'd0: return 8'((int'(a) + int'(b)) % 256);
      3'd1: return 8'((int'(a) - int'(b) + 256) % 256);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 8'd1 : 8'd0;
      3'd6: return 8'((int'(a) + int'(imm)) % 256);
      default: return imm;
    endcase
  endfunction

  logic [7:0] m_rf [8];
  int         m_age = 0;      // cycles since acceptance, 0 = idle
  logic       m_ready = 1'b1;
  logic       m_wen = 1'b0;
  logic       m_done = 1'b0;
  logic [2:0] m_rw = '0, m_rx = '0, m_ry = '0, m_rd = '0;
  logic [7:0] m_busw = '0, m_result = '0, m_pend = '0;

  initial for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;

  always @(posedge Clk) begin
    cyc++;
    if (m_wen) m_rf[m_rw] = m_busw;
    if (Reset) begin
      m_age = 0; m_ready = 1'b1; m_wen = 1'b0; m_done = 1'b0;
      m_rw = '0; m_rx = '0; m_ry = '0; m_busw = '0; m_result = '0;
    end else if (m_age == 0) begin
      if (bus.inst_valid) begin
        m_age = 1; m_ready = 1'b0;
        m_rx = bus.rs; m_ry = bus.rt; m_rd = bus.rd;
        m_pend = model_alu(bus.op, (bus.rs == 3'd0) ? 8'h00 : m_rf[bus.rs],
                           (bus.rt == 3'd0) ? 8'h00 : m_rf[bus.rt], bus.imm);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = 3; m_done = 1'b1; m_wen = (m_rd != 3'd0);
      m_rw = m_rd; m_busw = m_pend; m_result = m_pend;
    end else begin
      m_age = 0; m_ready = 1'b1; m_done = 1'b0; m_wen = 1'b0;
    end
    started = 1'b1;
  end

  // Per-cycle comparison and event monitors
  int hs_q[$];
  int done_q[$];
  int wen_cnt = 0;
  always @(negedge Clk) begin
    if (started) begin
      chk("inst_ready", int'(bus.inst_ready), int'(m_ready));
      chk("WEN", int'(bus.WEN), int'(m_wen));
      chk("done", int'(bus.done), int'(m_done));
      chk("RX", int'(bus.RX), int'(m_rx));
      chk("RY", int'(bus.RY), int'(m_ry));
      chk("RW", int'(bus.RW), int'(m_rw));
      chk("busW", int'(bus.busW), int'(m_busw));
      chk("result", int'(bus.result), int'(m_result));
      if (bus.inst_valid && bus.inst_ready && !Reset) hs_q.push_back(cyc);
      if (bus.done) done_q.push_back(cyc);
      if (bus.WEN) wen_cnt++;
    end
  end

  task automatic set_fields(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] rt, input logic [7:0] imm);
    bus.op = op; bus.rd = rd; bus.rs = rs; bus.rt = rt; bus.imm = imm;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.inst_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge Clk); #1;
  endtask

  task automatic wait_done(output logic [7:0] busw, output logic wen);
    bit ok = 1'b0;
    busw = '0; wen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.done) begin busw = bus.busW; wen = bus.WEN; ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [7:0] imm,
                       output logic [7:0] busw, output logic wen);
    bus.inst_valid = 1'b1;
    set_fields(op, rd, rs, rt, imm);
    wait_ready();
    bus.inst_valid = 1'b0;
    set_fields(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    wait_done(busw, wen);
  endtask

  logic [7:0] bw;
  logic       we;
  int n0, d0, w0;

  initial begin
    bus.inst_valid = 1'b0;
    set_fields('0, '0, '0, '0, '0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ready", int'(bus.inst_ready), 1);
    chk("rst_result", int'(bus.result), 0);

    issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h7F, bw, we);
    issue(3'd7, 3'd2, 3'd0, 3'd0, 8'h01, bw, we);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 8'h00, bw, we);
    chk("add_busW", int'(bw), 8'h80);
    chk("add_WEN", int'(we), 1);
    @(posedge Clk); #1;
    chk("r3", int'(rf[3]), 8'h80);

    issue(3'd1, 3'd4, 3'd2, 3'd1, 8'h00, bw, we);
    chk("sub_busW", int'(bw), 8'h82);
    issue(3'd5, 3'd5, 3'd3, 3'd2, 8'h00, bw, we);
    chk("slt_busW", int'(bw), 8'h01);
    issue(3'd6, 3'd6, 3'd3, 3'd0, 8'h80, bw, we);
    chk("addi_busW", int'(bw), 8'h00);
    issue(3'd0, 3'd0, 3'd1, 3'd1, 8'h00, bw, we);
    chk("r0_WEN", int'(we), 0);
    @(posedge Clk); #1;
    chk("r0", int'(rf[0]), 0);

    // Dependent back-to-back pair
    issue(3'd4, 3'd1, 3'd1, 3'd1, 8'h00, bw, we);
    issue(3'd3, 3'd2, 3'd1, 3'd0, 8'h00, bw, we);
    chk("dep_busW", int'(bw), 8'h00);
    @(posedge Clk); #1;
    chk("r1", int'(rf[1]), 8'h00);

    // inst_valid held high across three instructions
    n0 = hs_q.size(); d0 = done_q.size();
    bus.inst_valid = 1'b1;
    set_fields(3'd7, 3'd1, 3'd0, 3'd0, 8'h11); wait_ready();
    set_fields(3'd7, 3'd2, 3'd0, 3'd0, 8'h22); wait_ready();
    set_fields(3'd0, 3'd3, 3'd1, 3'd2, 8'h00); wait_ready();
    bus.inst_valid = 1'b0;
    wait_done(bw, we);
    chk("stream_busW", int'(bw), 8'h33);
    if (hs_q.size() >= n0 + 3 && done_q.size() >= d0 + 3) begin
      chk("hs_gap1", hs_q[n0+1] - hs_q[n0], 4);
      chk("hs_gap2", hs_q[n0+2] - hs_q[n0+1], 4);
      for (int k = 0; k < 3; k++) chk("hs_to_done", done_q[d0+k] - hs_q[n0+k], 3);
    end else begin
      chk("stream_events", hs_q.size() - n0, 3);
    end

    // Reset during EXEC aborts the instruction
    issue(3'd7, 3'd7, 3'd0, 3'd0, 8'h5A, bw, we);
    @(posedge Clk); #1;
    d0 = done_q.size(); w0 = wen_cnt;
    bus.inst_valid = 1'b1;
    set_fields(3'd0, 3'd7, 3'd1, 3'd2, 8'h00);
    wait_ready();
    bus.inst_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_ready", int'(bus.inst_ready), 1);
    repeat (6) @(posedge Clk);
    #1;
    chk("abort_done", done_q.size() - d0, 0);
    chk("abort_wen", wen_cnt - w0, 0);
    chk("r7", int'(rf[7]), 8'h5A);

    // Random cycle-level stimulus with occasional resets
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 59) == 0);
      bus.inst_valid = ($urandom_range(0, 9) < 6);
      set_fields(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
    bus.inst_valid = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rf_final_r%0d", i), int'(rf[i]), int'(m_rf[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
